// File: rtl/ptp_ts_fifo.sv
// ptp_ts_fifo: PTP timestamp FIFO with a host-side holding register read as 32-bit words
module ptp_ts_fifo #(
    parameter int AW    = 2,
    parameter int TS_W  = 80,
    parameter int SEQ_W = 16,
    parameter int TYP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [TS_W-1:0]  wr_ts,
    input  logic [SEQ_W-1:0] wr_seq,
    input  logic [TYP_W-1:0] wr_type,
    input  logic             pop,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             hold_vld,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic [7:0]       drop_cnt,
    output logic             irq
);
    localparam int DEPTH = 2 ** AW;
    localparam int E_W   = TYP_W + SEQ_W + TS_W;

    logic [E_W-1:0] mem [DEPTH];
    logic [E_W-1:0] hold;
    logic [AW-1:0]  wptr, rptr;
    logic [2:0]     cnt3;
    logic [31:0]    word;
    logic           do_pop, do_wr, drop;

    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign irq    = ~empty | ovf;
    assign do_pop = pop & ~empty;
    assign do_wr  = wr_vld & (~full | pop);
    assign drop   = wr_vld & full & ~pop;
    assign cnt3   = 3'(count);

    always_comb begin
        word = rd_addr == 2'd0 ? hold[31:0] :
               rd_addr == 2'd1 ? hold[63:32] :
               rd_addr == 2'd2 ? {hold[TS_W+:16], hold[64+:16]} :
               {4'b0, hold_vld, ovf, 10'b0, drop_cnt, hold[TS_W+SEQ_W+:4], 1'b0, cnt3};
    end

    // RAM contents need no reset; a write lost to clr never reaches the array
    always_ff @(posedge clk)
        if (do_wr && !clr) mem[wptr] <= {wr_type, wr_seq, wr_ts};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            rd_data  <= '0;
        end else begin
            rd_data <= word;
            if (clr) begin
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                hold     <= '0;
                hold_vld <= 1'b0;
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (pop) hold_vld <= ~empty;
                if (do_pop) begin
                    hold <= mem[rptr];
                    rptr <= rptr + 1'b1;
                end
                if (do_wr) wptr <= wptr + 1'b1;
                count <= count + (AW+1)'(do_wr) - (AW+1)'(do_pop);
                if (drop) begin
                    ovf <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ptp_ts_fifo.sv
// tb_ptp_ts_fifo: scoreboard bench for ptp_ts_fifo (AW=2) with directed vectors
module tb_ptp_ts_fifo;
    typedef logic [99:0] ent_t;
    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic [5:0]  st;
    } item_t;

    localparam logic [32:0] M = 33'h0;

    logic        clk = 0, rst = 1, clr = 0, wr_vld = 0, pop = 0;
    logic [79:0] wr_ts = '0;
    logic [15:0] wr_seq = '0;
    logic [3:0]  wr_type = '0;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        hold_vld, empty, full, ovf, irq;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    ent_t        mq[$];
    ent_t        m_hold = '0;
    logic        m_hv = 0, m_ovf = 0;
    logic [7:0]  m_drop = '0;
    item_t       sb[$];
    logic        req = 0, rd_chk = 0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ptp_ts_fifo dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_vld(wr_vld), .wr_ts(wr_ts),
        .wr_seq(wr_seq), .wr_type(wr_type), .pop(pop), .rd_addr(rd_addr),
        .rd_data(rd_data), .hold_vld(hold_vld), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .drop_cnt(drop_cnt), .irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [3:0] t, input logic [15:0] s, input logic [79:0] ts);
        return {t, s, ts};
    endfunction

    function automatic logic [31:0] mword(input logic [1:0] a);
        logic [2:0] c = 3'(mq.size());
        return a == 2'd0 ? m_hold[31:0] :
               a == 2'd1 ? m_hold[63:32] :
               a == 2'd2 ? {m_hold[95:80], m_hold[79:64]} :
               {4'b0, m_hv, m_ovf, 10'b0, m_drop, m_hold[99:96], 1'b0, c};
    endfunction

    function automatic logic [5:0] mstat();
        logic [2:0] c = 3'(mq.size());
        return {c == 3'd0, c == 3'd4, c != 3'd0 || m_ovf, c};
    endfunction

    task automatic m_reset();
        mq.delete();
        m_hold = '0;
        m_hv = 0;
        m_ovf = 0;
        m_drop = '0;
    endtask

    // rd word is predicted from pre-edge state, status from post-edge state
    task automatic step(input logic w, input ent_t e, input logic p, input logic c,
                        input logic ck, input logic [1:0] a, input logic [32:0] hx, input string nm);
        item_t it;
        bit mf, me;
        wr_vld = w; {wr_type, wr_seq, wr_ts} = e; pop = p; clr = c; rd_addr = a; req = ck;
        it.nm = nm;
        it.rd = hx[32] ? hx[31:0] : mword(a);
        mf = mq.size() == 4;
        me = mq.size() == 0;
        if (c) m_reset();
        else begin
            if (p) begin
                if (!me) begin m_hold = mq.pop_front(); m_hv = 1; end
                else m_hv = 0;
            end
            if (w) begin
                if (!mf || p) mq.push_back(e);
                else begin m_ovf = 1; if (m_drop != 8'hFF) m_drop++; end
            end
        end
        it.st = mstat();
        if (ck) sb.push_back(it);
        @(posedge clk); #1;
        wr_vld = 0; pop = 0; clr = 0; req = 0;
    endtask

    task automatic wr(input ent_t e);  step(1, e, 0, 0, 0, 2'd0, M, ""); endtask
    task automatic pp();               step(0, '0, 1, 0, 0, 2'd0, M, ""); endtask
    task automatic idle();             step(0, '0, 0, 0, 0, 2'd0, M, ""); endtask
    task automatic rd(input logic [1:0] a, input string nm); step(0, '0, 0, 0, 1, a, M, nm); endtask
    task automatic rdh(input logic [1:0] a, input logic [31:0] h, input string nm);
        step(0, '0, 0, 0, 1, a, {1'b1, h}, nm);
    endtask

    always @(posedge clk) rd_chk <= req;

    always @(negedge clk) begin
        if (rd_chk) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                item_t it;
                it = sb.pop_front();
                chk(it.nm, rd_data, it.rd);
                chk({it.nm, "_status"}, {26'b0, empty, full, irq, count}, {26'b0, it.st});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_status", {24'b0, hold_vld, ovf, empty, full, irq, count}, {24'b0, 8'b0010_0000});
        chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
        rst = 0;
        rdh(2'd3, 32'h0, "rst_w3");

        wr(mk(4'h1, 16'h1234, 80'h0000_0000_0005_3B9A_C9FF));
        pp();
        rdh(2'd0, 32'h3B9AC9FF, "t1_ns");
        rdh(2'd1, 32'h00000005, "t1_sec");
        rdh(2'd2, 32'h12340000, "t1_seq");
        rdh(2'd3, 32'h08000010, "t1_w3");

        for (int i = 0; i < 4; i++) wr(mk(4'(i + 2), 16'(i), {16'(i + 'hA0), 32'(i), 32'(i * 100)}));
        rdh(2'd3, 32'h08000014, "t2_full");
        wr(mk(4'hF, 16'hDEAD, 80'h1));
        wr(mk(4'hF, 16'hBEEF, 80'h2));
        rdh(2'd3, 32'h0C000214, "t2_ovf");
        for (int i = 0; i < 4; i++) begin
            pp();
            rdh(2'd2, {16'(i), 16'(i + 'hA0)}, "t2_pop");
        end
        rd(2'd3, "t2_empty");
        step(0, '0, 0, 1, 1, 2'd3, M, "t2_clr");

        for (int i = 0; i < 4; i++) wr(mk(4'h5, 16'(16'h10 + i), 80'(i)));
        step(1, mk(4'h6, 16'h20, 80'h55), 1, 0, 1, 2'd3, M, "t3_popwr");
        rdh(2'd2, 32'h00100000, "t3_head");
        for (int i = 0; i < 4; i++) begin
            pp();
            rd(2'd2, "t3_pop");
        end

        step(1, mk(4'h7, 16'h77, 80'h77), 1, 0, 1, 2'd3, M, "t4_popwr");
        rd(2'd3, "t4_hv0");
        pp();
        rdh(2'd2, 32'h00770000, "t4_pop");

        for (int i = 0; i < 4; i++) wr(mk(4'h3, 16'(16'h30 + i), 80'(i)));
        for (int i = 0; i < 300; i++) wr(mk(4'hE, 16'(i), 80'(i)));
        rdh(2'd3, 32'h0C00FF74, "t5_sat");
        step(1, mk(4'h9, 16'h99, 80'h99), 1, 1, 1, 2'd3, M, "t5_clr");
        rdh(2'd3, 32'h0, "t5_after_clr");
        rd(2'd2, "t5_clr_hold");

        for (int i = 0; i < 4; i++) wr(mk(4'h8, 16'(16'h40 + i), 80'(i)));
        pp();
        rd(2'd3, "t6_pre_rst");
        idle();
        rst = 1;
        #2;
        chk("t6_rst_rd_data", rd_data, 32'h0);
        chk("t6_rst_status", {24'b0, hold_vld, ovf, empty, full, irq, count}, {24'b0, 8'b0010_0000});
        chk("t6_rst_drop_cnt", {24'b0, drop_cnt}, 32'h0);
        m_reset();
        #1 rst = 0;
        for (int k = 0; k < 10; k++) begin
            wr(mk(4'h9, 16'(k), {16'(k), 32'(k), 32'(k * 32'h1111_0001)}));
            pp();
            rd(2'd0, "t6_wrap");
        end
        idle();
        idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
